// File: rtl/cmd_proc_pkg.sv
// Shared types and constants for the command processor: opcodes, FSM states
// and the default response bytes.
package cmd_proc_pkg;

    typedef enum logic [3:0] {
        OP_NOP     = 4'h0,
        OP_SET_SPD = 4'h2,
        OP_CAL     = 4'h4,
        OP_MOVE    = 4'h6
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAL       = 3'd1,
        ST_MOVE      = 3'd2,
        ST_RESP      = 3'd3,
        ST_RESP_WAIT = 3'd4
    } state_t;

    localparam logic [7:0] DEF_ACK  = 8'hA5;
    localparam logic [7:0] DEF_NACK = 8'h5A;

endpackage

// File: rtl/cmd_tmo_cnt.sv
// Timeout counter shared by the CAL and MOVE states; expired is high while
// the count sits at all-ones, where it holds until cleared.
module cmd_tmo_cnt #(
    parameter int TMO_W = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_W-1:0] cnt;

    assign expired = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

endmodule

// File: rtl/cmd_proc.sv
// Command processor: accepts 16-bit command words, updates speed/heading,
// sequences calibration and square-counted moves, and answers with ACK/NACK.
//
// Handshakes: cmd_rdy is a level held by the producer; it is consumed in an
// IDLE cycle where clr_cmd_rdy is high (combinational). send_resp is a
// one-cycle request; resp holds its value until resp_sent is seen in RESP_WAIT.
module cmd_proc
    import cmd_proc_pkg::*;
#(
    parameter logic [7:0] ACK   = DEF_ACK,
    parameter logic [7:0] NACK  = DEF_NACK,
    parameter int         TMO_W = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    input  logic        cal_done,
    input  logic        edge_pulse,
    input  logic        resp_sent,
    output logic [11:0] speed,
    output logic [7:0]  heading,
    output logic        moving,
    output logic        strt_cal,
    output logic [7:0]  resp,
    output logic        send_resp,
    output logic        busy,
    output logic [2:0]  fsm_state
);

    state_t     state;
    logic [3:0] sq_cnt;
    logic       accept;
    logic       tmo_clr;
    logic       tmo_en;
    logic       tmo_expired;

    assign accept      = (state == ST_IDLE) && cmd_rdy;
    assign clr_cmd_rdy = rst_n && accept;
    assign fsm_state   = state;

    // A new CAL/MOVE starts from zero; each square crossed restarts the window.
    assign tmo_clr = accept || ((state == ST_MOVE) && edge_pulse);
    assign tmo_en  = (state == ST_CAL) || (state == ST_MOVE);

    cmd_tmo_cnt #(
        .TMO_W(TMO_W)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            speed     <= '0;
            heading   <= '0;
            moving    <= 1'b0;
            strt_cal  <= 1'b0;
            send_resp <= 1'b0;
            resp      <= '0;
            busy      <= 1'b0;
            sq_cnt    <= '0;
        end else begin
            strt_cal  <= 1'b0;
            send_resp <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_rdy) begin
                        busy <= 1'b1;
                        case (cmd[15:12])
                            OP_NOP: begin
                                resp      <= ACK;
                                send_resp <= 1'b1;
                                state     <= ST_RESP;
                            end
                            OP_SET_SPD: begin
                                speed     <= cmd[11:0];
                                resp      <= ACK;
                                send_resp <= 1'b1;
                                state     <= ST_RESP;
                            end
                            OP_CAL: begin
                                strt_cal <= 1'b1;
                                state    <= ST_CAL;
                            end
                            OP_MOVE: begin
                                heading <= cmd[11:4];
                                sq_cnt  <= cmd[3:0];
                                if (cmd[3:0] == 4'd0) begin
                                    resp      <= ACK;
                                    send_resp <= 1'b1;
                                    state     <= ST_RESP;
                                end else begin
                                    moving <= 1'b1;
                                    state  <= ST_MOVE;
                                end
                            end
                            default: begin
                                resp      <= NACK;
                                send_resp <= 1'b1;
                                state     <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_CAL: begin
                    if (cal_done) begin
                        resp      <= ACK;
                        send_resp <= 1'b1;
                        state     <= ST_RESP;
                    end else if (tmo_expired) begin
                        resp      <= NACK;
                        send_resp <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_MOVE: begin
                    // sq_cnt is nonzero throughout MOVE, so the decrement is safe.
                    if (edge_pulse) begin
                        sq_cnt <= sq_cnt - 4'd1;
                        if (sq_cnt == 4'd1) begin
                            moving    <= 1'b0;
                            resp      <= ACK;
                            send_resp <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end else if (tmo_expired) begin
                        moving    <= 1'b0;
                        resp      <= NACK;
                        send_resp <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_RESP_WAIT;
                end
                ST_RESP_WAIT: begin
                    if (resp_sent) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_proc.sv
// Directed bench for cmd_proc: a table of single-shot commands plus
// hand-written sequences for calibration, moves, pending commands and reset.
module tb_cmd_proc;
    import cmd_proc_pkg::*;

    localparam int TMO_W = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        cal_done;
    logic        edge_pulse;
    logic        resp_sent;
    logic [11:0] speed;
    logic [7:0]  heading;
    logic        moving;
    logic        strt_cal;
    logic [7:0]  resp;
    logic        send_resp;
    logic        busy;
    logic [2:0]  fsm_state;

    cmd_proc #(.TMO_W(TMO_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cal_done   (cal_done),
        .edge_pulse (edge_pulse),
        .resp_sent  (resp_sent),
        .speed      (speed),
        .heading    (heading),
        .moving     (moving),
        .strt_cal   (strt_cal),
        .resp       (resp),
        .send_resp  (send_resp),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   n_checks;
    int   n_err;
    int   n_send;
    int   n_cal;
    int   n_clr;
    logic saw_moving;

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  exp_resp;
        logic [11:0] exp_speed;
        logic [7:0]  exp_heading;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (send_resp) n_send++;
        if (strt_cal) n_cal++;
        if (clr_cmd_rdy) n_clr++;
        if (moving) saw_moving = 1'b1;
    endtask

    task automatic issue(input logic [15:0] c);
        cmd     = c;
        cmd_rdy = 1'b1;
        #1;
        check("clr_cmd_rdy_mealy", clr_cmd_rdy, 1);
        tick();
        cmd_rdy = 1'b0;
    endtask

    // Wait for send_resp, then complete the transmit handshake immediately.
    task automatic finish_cmd(input int budget, output logic [7:0] got, output int lat);
        lat = 0;
        while (!send_resp && lat < budget) begin
            tick();
            lat++;
        end
        check("send_resp_seen", send_resp, 1);
        got = resp;
        tick();
        check("send_resp_one_cycle", send_resp, 0);
        check("state_resp_wait", fsm_state, ST_RESP_WAIT);
        check("resp_stable", resp, got);
        check("busy_in_resp_wait", busy, 1);
        resp_sent = 1'b1;
        tick();
        resp_sent = 1'b0;
        check("state_idle_after_sent", fsm_state, ST_IDLE);
        check("busy_low_after_sent", busy, 0);
    endtask

    initial begin
        logic [7:0] got;
        int         lat;
        int         send_before;

        n_checks = 0; n_err = 0; n_send = 0; n_cal = 0; n_clr = 0;
        saw_moving = 1'b0;
        rst_n = 1'b0; cmd = '0; cmd_rdy = 1'b0;
        cal_done = 1'b0; edge_pulse = 1'b0; resp_sent = 1'b0;

        vecs[0] = '{16'h0000, 8'hA5, 12'h000, 8'h00};
        vecs[1] = '{16'h2123, 8'hA5, 12'h123, 8'h00};
        vecs[2] = '{16'hF0FF, 8'h5A, 12'h123, 8'h00};
        vecs[3] = '{16'h6450, 8'hA5, 12'h123, 8'h45};
        vecs[4] = '{16'h1ABC, 8'h5A, 12'h123, 8'h45};
        vecs[5] = '{16'h2FFF, 8'hA5, 12'hFFF, 8'h45};
        vecs[6] = '{16'h8765, 8'h5A, 12'hFFF, 8'h45};
        vecs[7] = '{16'h6000, 8'hA5, 12'hFFF, 8'h00};

        repeat (3) tick();
        check("rst_speed", speed, 0);
        check("rst_heading", heading, 0);
        check("rst_moving", moving, 0);
        check("rst_strt_cal", strt_cal, 0);
        check("rst_send_resp", send_resp, 0);
        check("rst_resp", resp, 0);
        check("rst_busy", busy, 0);
        check("rst_clr_cmd_rdy", clr_cmd_rdy, 0);
        check("rst_state", fsm_state, ST_IDLE);
        rst_n = 1'b1;
        tick();

        // Inputs that only matter in other states must not disturb IDLE.
        send_before = n_send;
        edge_pulse = 1'b1; resp_sent = 1'b1; cal_done = 1'b1;
        tick();
        edge_pulse = 1'b0; resp_sent = 1'b0; cal_done = 1'b0;
        tick();
        check("idle_ignore_state", fsm_state, ST_IDLE);
        check("idle_ignore_busy", busy, 0);
        check("idle_ignore_send", n_send, send_before);

        for (int i = 0; i < 8; i++) begin
            n_cal = 0;
            saw_moving = 1'b0;
            issue(vecs[i].cmd);
            check("vec_speed_next_edge", speed, vecs[i].exp_speed);
            check("vec_busy", busy, 1);
            finish_cmd(20, got, lat);
            check("vec_resp", got, vecs[i].exp_resp);
            check("vec_latency", lat, 0);
            check("vec_speed", speed, vecs[i].exp_speed);
            check("vec_heading", heading, vecs[i].exp_heading);
            check("vec_no_moving", saw_moving, 0);
            check("vec_no_strt_cal", n_cal, 0);
        end

        // CAL with no cal_done: NACK once the 4-bit counter reaches 15.
        n_cal = 0;
        issue(16'h4000);
        check("cal_strt_cal_high", strt_cal, 1);
        check("cal_state", fsm_state, ST_CAL);
        finish_cmd(40, got, lat);
        check("cal_tmo_latency", lat, 16);
        check("cal_tmo_resp", got, 8'h5A);
        check("cal_one_strt_cal", n_cal, 1);
        check("cal_speed_kept", speed, 12'hFFF);

        // CAL with cal_done on the expiry cycle: cal_done wins.
        n_cal = 0;
        issue(16'h4000);
        repeat (15) tick();
        check("cal_still_cal", fsm_state, ST_CAL);
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        finish_cmd(4, got, lat);
        check("cal_done_resp", got, 8'hA5);
        check("cal_done_latency", lat, 0);
        check("cal_done_one_strt", n_cal, 1);

        // MOVE of three squares with a second command pending mid-move.
        saw_moving = 1'b0;
        issue(16'h6C33);
        check("move_heading", heading, 8'hC3);
        check("move_moving", moving, 1);
        check("move_state", fsm_state, ST_MOVE);
        repeat (9) tick();
        edge_pulse = 1'b1;
        tick();
        edge_pulse = 1'b0;
        cmd = 16'h2456;
        cmd_rdy = 1'b1;
        n_clr = 0;
        #1;
        check("pending_not_cleared", clr_cmd_rdy, 0);
        for (int p = 0; p < 2; p++) begin
            check("move_moving_mid", moving, 1);
            repeat (9) tick();
            edge_pulse = 1'b1;
            tick();
            edge_pulse = 1'b0;
        end
        check("move_done_moving", moving, 0);
        check("move_done_state", fsm_state, ST_RESP);
        check("pending_speed_untouched", speed, 12'hFFF);
        finish_cmd(4, got, lat);
        check("move_resp", got, 8'hA5);
        check("move_heading_kept", heading, 8'hC3);
        check("pending_clr_once", n_clr, 1);
        check("pending_clr_now", clr_cmd_rdy, 1);
        tick();
        cmd_rdy = 1'b0;
        check("pending_speed", speed, 12'h456);
        finish_cmd(4, got, lat);
        check("pending_resp", got, 8'hA5);

        // MOVE with no edge_pulse: timeout NACK and moving drops.
        issue(16'h6A51);
        check("move_tmo_heading", heading, 8'hA5);
        finish_cmd(40, got, lat);
        check("move_tmo_latency", lat, 16);
        check("move_tmo_resp", got, 8'h5A);
        check("move_tmo_moving", moving, 0);

        // Reset mid-MOVE aborts without a response.
        issue(16'h6A53);
        repeat (3) tick();
        edge_pulse = 1'b1; tick(); edge_pulse = 1'b0;
        repeat (3) tick();
        edge_pulse = 1'b1; tick(); edge_pulse = 1'b0;
        check("rstmove_moving_before", moving, 1);
        send_before = n_send;
        rst_n = 1'b0;
        #1;
        check("rstmove_moving", moving, 0);
        check("rstmove_heading", heading, 0);
        check("rstmove_busy", busy, 0);
        check("rstmove_state", fsm_state, ST_IDLE);
        check("rstmove_speed", speed, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("rstmove_no_send", n_send, send_before);
        check("rstmove_idle_after", fsm_state, ST_IDLE);

        issue(16'h0000);
        finish_cmd(4, got, lat);
        check("post_reset_nop", got, 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
